// File: rtl/e203_exu_oitf_pkg.sv
// Shared core sizing for the outstanding instruction track FIFO and its pointer counters.
// Pure constants and a helper; no logic, no latency, no flow control.
// Other blocks import these values so that itag widths agree across the core.
package e203_exu_oitf_pkg;

    localparam int E203_OITF_DEPTH  = 2;
    localparam int E203_ITAG_WIDTH  = (E203_OITF_DEPTH > 1) ? $clog2(E203_OITF_DEPTH) : 1;
    localparam int E203_RFIDX_WIDTH = 5;
    localparam int E203_PC_SIZE     = 32;

    // One architectural register operand as seen by the hazard comparators.
    typedef struct packed {
        logic                        en;
        logic                        fpu;
        logic [E203_RFIDX_WIDTH-1:0] idx;
    } reg_ref_t;

endpackage

// File: rtl/e203_exu_oitf_ptr.sv
// Circular pointer with a wrap flag; the flag tells full from empty when two pointers are equal.
// Single-cycle: ptr/flg update on the clock edge after inc.
// No backpressure; the caller only pulses inc on a legal move.
module e203_exu_oitf_ptr #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic         flg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            flg <= 1'b0;
        end else if (inc) begin
            if (ptr == W'(DEPTH - 1)) begin
                ptr <= '0;
                flg <= ~flg;
            end else begin
                ptr <= ptr + W'(1);
            end
        end
    end

endmodule

// File: rtl/e203_exu_oitf.sv
// Outstanding instruction track FIFO: itag allocation for long-pipe ops plus RAW/WAW hazard flags.
// Entries are visible on ret_* and in hazard matching one cycle after dispatch; ret_*/matches are combinational.
// dis_ready drops when full (independent of ret_ena); retire on empty and dispatch on full are ignored.
module e203_exu_oitf
    import e203_exu_oitf_pkg::*;
#(
    parameter int DEPTH       = E203_OITF_DEPTH,
    parameter int ITAG_WIDTH  = E203_ITAG_WIDTH,
    parameter int RFIDX_WIDTH = E203_RFIDX_WIDTH,
    parameter int PC_SIZE     = E203_PC_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   dis_ready,
    input  logic                   dis_ena,
    output logic [ITAG_WIDTH-1:0]  dis_ptr,
    input  logic                   disp_i_rdwen,
    input  logic                   disp_i_rdfpu,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic                   disp_i_rs3en,
    input  logic                   disp_i_rs1fpu,
    input  logic                   disp_i_rs2fpu,
    input  logic                   disp_i_rs3fpu,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprs3,
    output logic                   oitfrd_match_disprd,
    input  logic                   ret_ena,
    output logic [ITAG_WIDTH-1:0]  ret_ptr,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic                   ret_rdwen,
    output logic                   ret_rdfpu,
    output logic [PC_SIZE-1:0]     ret_pc,
    output logic                   oitf_empty
);

    logic [ITAG_WIDTH-1:0] alc_ptr;
    logic                  alc_flg;
    logic                  ret_flg;
    logic                  full;
    logic                  dis_fire;
    logic                  ret_fire;

    logic [DEPTH-1:0]       vld;
    logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic                   rdwen_q [DEPTH];
    logic                   rdfpu_q [DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [DEPTH];

    assign oitf_empty = (alc_ptr == ret_ptr) && (alc_flg == ret_flg);
    assign full       = (alc_ptr == ret_ptr) && (alc_flg != ret_flg);
    assign dis_ready  = ~full;
    assign dis_ptr    = alc_ptr;
    assign dis_fire   = dis_ena & ~full;
    assign ret_fire   = ret_ena & ~oitf_empty;

    e203_exu_oitf_ptr #(.DEPTH(DEPTH), .W(ITAG_WIDTH)) u_alc_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dis_fire),
        .ptr   (alc_ptr),
        .flg   (alc_flg)
    );

    e203_exu_oitf_ptr #(.DEPTH(DEPTH), .W(ITAG_WIDTH)) u_ret_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ret_fire),
        .ptr   (ret_ptr),
        .flg   (ret_flg)
    );

    // Alloc and retire slots only coincide when empty or full, where one side is already blocked.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[i] <= 1'b0;
            end else if (dis_fire && (alc_ptr == ITAG_WIDTH'(i))) begin
                vld[i] <= 1'b1;
            end else if (ret_fire && (ret_ptr == ITAG_WIDTH'(i))) begin
                vld[i] <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (dis_fire && (alc_ptr == ITAG_WIDTH'(i))) begin
                rdidx_q[i] <= disp_i_rdidx;
                rdwen_q[i] <= disp_i_rdwen;
                rdfpu_q[i] <= disp_i_rdfpu;
                pc_q[i]    <= disp_i_pc;
            end
        end
    end

    assign ret_rdidx = rdidx_q[ret_ptr];
    assign ret_rdwen = vld[ret_ptr] & rdwen_q[ret_ptr];
    assign ret_rdfpu = vld[ret_ptr] & rdfpu_q[ret_ptr];
    assign ret_pc    = pc_q[ret_ptr];

    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprs3 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && rdwen_q[i]) begin
                oitfrd_match_disprs1 |= disp_i_rs1en && (rdfpu_q[i] == disp_i_rs1fpu) && (rdidx_q[i] == disp_i_rs1idx);
                oitfrd_match_disprs2 |= disp_i_rs2en && (rdfpu_q[i] == disp_i_rs2fpu) && (rdidx_q[i] == disp_i_rs2idx);
                oitfrd_match_disprs3 |= disp_i_rs3en && (rdfpu_q[i] == disp_i_rs3fpu) && (rdidx_q[i] == disp_i_rs3idx);
                oitfrd_match_disprd  |= disp_i_rdwen && (rdfpu_q[i] == disp_i_rdfpu)  && (rdidx_q[i] == disp_i_rdidx);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(ret_ena && oitf_empty)) else $warning("oitf: retire requested while empty, ignored");
            assert (!(dis_ena && full))       else $warning("oitf: dispatch requested while full, ignored");
        end
    end
`endif

endmodule

// File: tb/tb_e203_exu_oitf.sv
module tb_e203_exu_oitf;
    localparam int DEPTH = 2;
    localparam int IW    = 1;
    localparam int RW    = 5;
    localparam int PW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dis_ready, dis_ena;
    logic [IW-1:0] dis_ptr, ret_ptr;
    logic          disp_i_rdwen, disp_i_rdfpu;
    logic [RW-1:0] disp_i_rdidx;
    logic [PW-1:0] disp_i_pc;
    logic          disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
    logic          disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
    logic [RW-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx;
    logic          m_rs1, m_rs2, m_rs3, m_rd;
    logic          ret_ena;
    logic [RW-1:0] ret_rdidx;
    logic          ret_rdwen, ret_rdfpu;
    logic [PW-1:0] ret_pc;
    logic          oitf_empty;

    always #5 clk = ~clk;

    e203_exu_oitf dut (
        .clk(clk), .rst_n(rst_n),
        .dis_ready(dis_ready), .dis_ena(dis_ena), .dis_ptr(dis_ptr),
        .disp_i_rdwen(disp_i_rdwen), .disp_i_rdfpu(disp_i_rdfpu),
        .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
        .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu), .disp_i_rs3fpu(disp_i_rs3fpu),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
        .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
        .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc),
        .oitf_empty(oitf_empty)
    );

    // Reference: in-order list of outstanding instructions plus total alloc/retire counts.
    typedef struct {
        logic [RW-1:0] rdidx;
        logic          rdwen;
        logic          rdfpu;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   alc_n = 0;
    int   ret_n = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic en, input logic fpu, input logic [RW-1:0] idx);
        foreach (q[i])
            if (en && q[i].rdwen && q[i].rdfpu == fpu && q[i].rdidx == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        chk("empty", oitf_empty, q.size() == 0);
        chk("dis_ready", dis_ready, q.size() < DEPTH);
        chk("dis_ptr", dis_ptr, alc_n % DEPTH);
        chk("ret_ptr", ret_ptr, ret_n % DEPTH);
        if (q.size() > 0) begin
            chk("ret_rdidx", ret_rdidx, q[0].rdidx);
            chk("ret_rdwen", ret_rdwen, q[0].rdwen);
            chk("ret_rdfpu", ret_rdfpu, q[0].rdfpu);
            chk("ret_pc", ret_pc, q[0].pc);
        end
        chk("match_rs1", m_rs1, hit(disp_i_rs1en, disp_i_rs1fpu, disp_i_rs1idx));
        chk("match_rs2", m_rs2, hit(disp_i_rs2en, disp_i_rs2fpu, disp_i_rs2idx));
        chk("match_rs3", m_rs3, hit(disp_i_rs3en, disp_i_rs3fpu, disp_i_rs3idx));
        chk("match_rd", m_rd, hit(disp_i_rdwen, disp_i_rdfpu, disp_i_rdidx));
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock.
    task automatic step();
        bit   dfire, rfire;
        ent_t e;
        #1 check_all();
        dfire = dis_ena && (q.size() < DEPTH);
        rfire = ret_ena && (q.size() > 0);
        e.rdidx = disp_i_rdidx; e.rdwen = disp_i_rdwen; e.rdfpu = disp_i_rdfpu; e.pc = disp_i_pc;
        @(posedge clk);
        if (rfire) begin void'(q.pop_front()); ret_n++; end
        if (dfire) begin q.push_back(e); alc_n++; end
        @(negedge clk);
    endtask

    task automatic set_disp(input logic de, input logic re, input logic wen, input logic fpu,
                            input logic [RW-1:0] idx, input logic [PW-1:0] pc);
        dis_ena = de; ret_ena = re;
        disp_i_rdwen = wen; disp_i_rdfpu = fpu; disp_i_rdidx = idx; disp_i_pc = pc;
    endtask

    task automatic clr_src();
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0;
        disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0;
        disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rs3idx = 0;
    endtask

    initial begin
        logic [IW-1:0] exp_tag;
        rst_n = 1'b0;
        set_disp(0, 0, 0, 0, 0, 0);
        clr_src();
        #12 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        #1;
        chk("rst_empty", oitf_empty, 1'b1);
        chk("rst_dis_ready", dis_ready, 1'b1);
        chk("rst_dis_ptr", dis_ptr, 0);
        chk("rst_ret_ptr", ret_ptr, 0);
        chk("rst_matches", {m_rs1, m_rs2, m_rs3, m_rd}, 4'b0000);
        step();

        // First dispatch becomes visible next cycle
        set_disp(1, 0, 1, 0, 5'd5, 32'h8000_0010);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_rdidx", ret_rdidx, 5);
        chk("t1_rdwen", ret_rdwen, 1'b1);
        chk("t1_pc", ret_pc, 32'h8000_0010);
        chk("t1_empty", oitf_empty, 1'b0);
        chk("t1_dis_ptr", dis_ptr, 1);
        step();

        // Fill, then dispatch+retire while full: only the retire happens
        set_disp(1, 0, 1, 1, 5'd6, 32'h8000_0014);
        step();
        #1 chk("full_dis_ready", dis_ready, 1'b0);
        set_disp(1, 1, 1, 0, 5'd8, 32'h8000_0018);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        #1 chk("after_full_ready", dis_ready, 1'b1);
        step();

        // Dispatch/retire rounds across pointer wrap
        for (int r = 0; r < 5; r++) begin
            set_disp(1, 0, 1, r[0], 5'(r + 10), 32'h9000_0000 + 32'(r * 4));
            step();
            set_disp(0, 1, 0, 0, 0, 0);
            step();
        end
        set_disp(0, 1, 0, 0, 0, 0);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        #1 chk("drained_empty", oitf_empty, 1'b1);

        // RAW matching on rs2
        set_disp(1, 0, 1, 0, 5'd7, 32'hA000_0000);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        disp_i_rs2en = 1; disp_i_rs2idx = 5'd7; disp_i_rs2fpu = 0;
        #1 chk("raw_int_hit", m_rs2, 1'b1);
        disp_i_rs2fpu = 1;
        #1 chk("raw_fpu_miss", m_rs2, 1'b0);
        step();
        disp_i_rs2fpu = 0;
        set_disp(1, 1, 0, 0, 5'd7, 32'hA000_0004);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        #1 chk("raw_nowen_miss", m_rs2, 1'b0);
        clr_src();
        step();

        // Simultaneous dispatch and retire at occupancy 1
        exp_tag = IW'((ret_n + 1) % DEPTH);
        set_disp(1, 1, 1, 0, 5'd3, 32'hB000_0000);
        #1 chk("sim_tag", dis_ptr, exp_tag);
        step();
        set_disp(0, 0, 0, 0, 0, 0);
        #1;
        chk("sim_occ", {oitf_empty, dis_ready}, 2'b01);
        chk("sim_ret_pc", ret_pc, 32'hB000_0000);
        step();

        // Randomized legal traffic against the reference
        for (int n = 0; n < 400; n++) begin
            set_disp(($urandom_range(0, 1) == 1) && (q.size() < DEPTH),
                     ($urandom_range(0, 2) == 0) && (q.size() > 0),
                     1'($urandom), 1'($urandom), RW'($urandom_range(0, 7)), $urandom);
            disp_i_rs1en = 1'($urandom); disp_i_rs1fpu = 1'($urandom); disp_i_rs1idx = RW'($urandom_range(0, 7));
            disp_i_rs2en = 1'($urandom); disp_i_rs2fpu = 1'($urandom); disp_i_rs2idx = RW'($urandom_range(0, 7));
            disp_i_rs3en = 1'($urandom); disp_i_rs3fpu = 1'($urandom); disp_i_rs3idx = RW'($urandom_range(0, 7));
            step();
        end

        // Asynchronous reset with two valid entries
        clr_src();
        set_disp(0, 0, 0, 0, 0, 0);
        while (q.size() > 0) begin ret_ena = 1; step(); end
        set_disp(1, 0, 1, 0, 5'd9, 32'hC000_0000);
        step();
        set_disp(1, 0, 1, 0, 5'd9, 32'hC000_0004);
        step();
        set_disp(0, 0, 1, 0, 5'd9, 32'h0);
        disp_i_rs1en = 1; disp_i_rs1idx = 5'd9;
        #1 chk("pre_rst_match", m_rs1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_empty", oitf_empty, 1'b1);
        chk("arst_matches", {m_rs1, m_rs2, m_rs3, m_rd}, 4'b0000);
        chk("arst_ready", dis_ready, 1'b1);
        q.delete(); alc_n = 0; ret_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clr_src();
        set_disp(0, 0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
